// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and helpers for the data-RAM arbiter.
// The RAM window covers the low 64 KB of the byte address space.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2
  } state_t;

  localparam logic [15:0] RAM_WINDOW_HI = 16'h0000;
  localparam logic        MST0          = 1'b0;
  localparam logic        MST1          = 1'b1;

  function automatic logic in_window(input logic [31:0] addr);
    return addr[31:16] == RAM_WINDOW_HI;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master's request/acknowledge bus into the data-RAM arbiter.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, wstrb, addr, wdata, input ready, rdata, err);
  modport slave  (input req, we, wstrb, addr, wdata, output ready, rdata, err);
endinterface

// File: rtl/dmem_arbiter_arb_rr2.sv
// Combinational two-way picker: masks excluded requesters, then resolves a tie
// either by fixed priority (requester 0) or in favour of the one not served last.
module arb_rr2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] excl,
  input  logic       last,
  input  logic       prio,
  output logic [1:0] gnt
);
  logic [1:0] cand;

  always_comb begin
    cand = req & ~excl;
    gnt  = cand;
    if (cand == 2'b11) begin
      gnt = (prio || (last == MST1)) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer onto the single-port data RAM; each access is
// acknowledged in its single ACC cycle with combinational read data.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int PRIORITY = 0,
  parameter int AW       = 14
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [3:0]    ram_wstrb,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          busy
);
  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [1:0]  excl;
  logic [1:0]  gnt;
  logic        acc;
  logic        sel1;
  logic        in_range;
  logic [31:0] sel_addr;
  logic        unused_addr_lsb;

  // The current owner still holds req on its ack edge, so it is masked out.
  assign excl = {state == ST_ACC1, state == ST_ACC0};

  arb_rr2 u_arb (
    .req  ({m1.req, m0.req}),
    .excl (excl),
    .last (last),
    .prio (PRIORITY != 0),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      last  <= MST1;
    end else begin
      state <= state_nxt;
      if (state == ST_ACC0) begin
        last <= MST0;
      end else if (state == ST_ACC1) begin
        last <= MST1;
      end
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (gnt[0]) begin
      state_nxt = ST_ACC0;
    end else if (gnt[1]) begin
      state_nxt = ST_ACC1;
    end
  end

  assign acc             = (state == ST_ACC0) || (state == ST_ACC1);
  assign sel1            = (state == ST_ACC1);
  assign sel_addr        = sel1 ? m1.addr : m0.addr;
  assign in_range        = in_window(sel_addr);
  assign unused_addr_lsb = ^sel_addr[1:0];

  // Address/wdata are left on master 0 when idle; strobe, we and acks are gated.
  always_comb begin
    ram_addr  = sel_addr[AW+1:2];
    ram_wdata = sel1 ? m1.wdata : m0.wdata;
    ram_wstrb = 4'b0000;
    ram_we    = 1'b0;
    busy      = acc;
    m0.ready  = 1'b0;
    m0.err    = 1'b0;
    m0.rdata  = 32'h0;
    m1.ready  = 1'b0;
    m1.err    = 1'b0;
    m1.rdata  = 32'h0;
    if (acc) begin
      ram_wstrb = sel1 ? m1.wstrb : m0.wstrb;
      ram_we    = (sel1 ? m1.we : m0.we) & in_range;
    end
    if (state == ST_ACC0) begin
      m0.ready = 1'b1;
      m0.err   = ~in_range;
      if (in_range) m0.rdata = ram_rdata;
    end
    if (state == ST_ACC1) begin
      m1.ready = 1'b1;
      m1.err   = ~in_range;
      if (in_range) m1.rdata = ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level model
// (pending-requester choice + reference memory), plus a fixed-priority instance.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW   = 14;
  localparam int PRIO = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req_v, we_v;
  logic [1:0][3:0]  strb_v;
  logic [1:0][31:0] addr_v, wdata_v;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter_if m0_bus ();
  dmem_arbiter_if m1_bus ();
  dmem_arbiter_if f0_bus ();
  dmem_arbiter_if f1_bus ();

  assign m0_bus.req = req_v[0]; assign m0_bus.we = we_v[0]; assign m0_bus.wstrb = strb_v[0];
  assign m0_bus.addr = addr_v[0]; assign m0_bus.wdata = wdata_v[0];
  assign m1_bus.req = req_v[1]; assign m1_bus.we = we_v[1]; assign m1_bus.wstrb = strb_v[1];
  assign m1_bus.addr = addr_v[1]; assign m1_bus.wdata = wdata_v[1];
  assign f0_bus.req = req_v[0]; assign f0_bus.we = we_v[0]; assign f0_bus.wstrb = strb_v[0];
  assign f0_bus.addr = addr_v[0]; assign f0_bus.wdata = wdata_v[0];
  assign f1_bus.req = req_v[1]; assign f1_bus.we = we_v[1]; assign f1_bus.wstrb = strb_v[1];
  assign f1_bus.addr = addr_v[1]; assign f1_bus.wdata = wdata_v[1];

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          busy;

  dmem_arbiter #(.PRIORITY(PRIO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wstrb(ram_wstrb),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  logic [AW-1:0] fx_addr;
  logic          fx_we, fx_busy;
  logic [3:0]    fx_wstrb;
  logic [31:0]   fx_wdata;

  dmem_arbiter #(.PRIORITY(1), .AW(AW)) dut_fix (
    .clk(clk), .rst(rst), .m0(f0_bus), .m1(f1_bus),
    .ram_addr(fx_addr), .ram_we(fx_we), .ram_wstrb(fx_wstrb),
    .ram_wdata(fx_wdata), .ram_rdata(32'h0), .busy(fx_busy)
  );

  logic [1:0]       rdy, errs, fx_rdy;
  logic [1:0][31:0] rdat;
  assign rdy    = {m1_bus.ready, m0_bus.ready};
  assign errs   = {m1_bus.err, m0_bus.err};
  assign rdat   = {m1_bus.rdata, m0_bus.rdata};
  assign fx_rdy = {f1_bus.ready, f0_bus.ready};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    merge = old;
    for (int b = 0; b < 4; b++) if (strb[b]) merge[b*8 +: 8] = nw[b*8 +: 8];
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return a[31:16] == 16'h0000;
  endfunction

  // Choose who is served next: anyone requesting other than the master just served;
  // a tie goes to master 0 under fixed priority, else to the one that did not win last.
  function automatic int pick(input logic [1:0] req, input int served, input int last_won);
    bit w0, w1;
    w0 = req[0] && (served != 0);
    w1 = req[1] && (served != 1);
    if (w0 && w1) return (PRIO != 0) ? 0 : 1 - last_won;
    if (w0) return 0;
    if (w1) return 1;
    return -1;
  endfunction

  // Bench-side RAM driven by the DUT's RAM port.
  bit [31:0] ram [0:16383];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_wstrb);

  // Reference model: who owns each cycle, and what memory must hold.
  int        exp_owner;
  int        mdl_last;
  bit [31:0] ref_mem [0:16383];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_owner <= -1;
      mdl_last  <= 1;
    end else begin
      if (exp_owner >= 0) begin
        if (we_v[exp_owner] && in_win(addr_v[exp_owner]))
          ref_mem[addr_v[exp_owner][15:2]] <= merge(ref_mem[addr_v[exp_owner][15:2]],
                                                    wdata_v[exp_owner], strb_v[exp_owner]);
        mdl_last <= exp_owner;
      end
      exp_owner <= pick(req_v, exp_owner, mdl_last);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_ready", {30'h0, rdy}, 32'h0);
      check("rst_err", {30'h0, errs}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_ram_we", {31'h0, ram_we}, 32'h0);
      check("rst_ram_wstrb", {28'h0, ram_wstrb}, 32'h0);
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit own, ok;
        own = (exp_owner == m);
        ok  = own && in_win(addr_v[m]);
        check($sformatf("m%0d_ready", m), {31'h0, rdy[m]}, {31'h0, own});
        check($sformatf("m%0d_err", m), {31'h0, errs[m]}, {31'h0, own && !ok});
        check($sformatf("m%0d_rdata", m), rdat[m], ok ? ref_mem[addr_v[m][15:2]] : 32'h0);
      end
      check("busy", {31'h0, busy}, {31'h0, exp_owner >= 0});
      check("ready_without_req", {30'h0, rdy & ~req_v}, 32'h0);
      check("both_ready", {31'h0, &rdy}, 32'h0);
      if (exp_owner >= 0) begin
        check("ram_we", {31'h0, ram_we},
              {31'h0, we_v[exp_owner] && in_win(addr_v[exp_owner])});
        check("ram_wstrb", {28'h0, ram_wstrb}, {28'h0, strb_v[exp_owner]});
        check("ram_addr", {18'h0, ram_addr}, {18'h0, addr_v[exp_owner][AW+1:2]});
        check("ram_wdata", ram_wdata, wdata_v[exp_owner]);
        check("req_held_in_acc", {31'h0, req_v[exp_owner]}, 32'h1);
      end else begin
        check("idle_ram_we", {31'h0, ram_we}, 32'h0);
        check("idle_ram_wstrb", {28'h0, ram_wstrb}, 32'h0);
      end
    end
  end

  task automatic set_txn(input int m, input logic we, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata);
    we_v[m] = we; strb_v[m] = strb; addr_v[m] = addr; wdata_v[m] = wdata; req_v[m] = 1'b1;
  endtask

  task automatic rand_txn(input int m);
    logic [31:0] a;
    if ($urandom_range(7) == 0) a = {16'($urandom_range(16'hFFFF, 1)), 16'($urandom)};
    else                        a = {16'h0, 6'h0, 8'($urandom), 2'($urandom)};
    set_txn(m, 1'($urandom), 4'($urandom), a, $urandom);
  endtask

  task automatic cycle(output logic [1:0] seen);
    @(negedge clk);
    seen = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input int m, input logic we, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er, output int lat);
    bit got;
    got = 0; lat = 0; rd = 32'h0; er = 1'b0;
    set_txn(m, we, strb, addr, wdata);
    while (!got && lat < 8) begin
      @(negedge clk);
      if (rdy[m]) begin got = 1; rd = rdat[m]; er = errs[m]; end
      else lat++;
    end
    check("access_acked", {31'h0, got}, 32'h1);
    @(posedge clk);
    #1;
    req_v[m] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, done_cnt;
    int          wait_cyc [2];
    logic [1:0]  seen;
    bit          stall;

    req_v = '0; we_v = '0; strb_v = '0; addr_v = '0; wdata_v = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single read after reset, one-cycle latency.
    do_access(0, 1'b1, 4'hF, 32'h0000_0014, 32'hDEADBEEF, rd, er, lat);
    do_access(0, 1'b0, 4'h0, 32'h0000_0014, 32'h0, rd, er, lat);
    check("rd5_data", rd, 32'hDEADBEEF);
    check("rd5_err", {31'h0, er}, 32'h0);
    check("rd5_latency", lat, 1);
    @(negedge clk);
    check("rd5_idle_after", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;

    // Byte write from master 1 merges into the existing word.
    do_access(0, 1'b1, 4'hF, 32'h0000_0020, 32'h11223344, rd, er, lat);
    do_access(1, 1'b1, 4'b0100, 32'h0000_0020, 32'h00AB0000, rd, er, lat);
    check("bytewr_latency", lat, 1);
    do_access(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, rd, er, lat);
    check("bytewr_readback", rd, 32'h11AB3344);

    // Out-of-range write is acked with err and leaves word 0 alone.
    do_access(0, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFEF00D, rd, er, lat);
    do_access(0, 1'b1, 4'hF, 32'hFFFF_0000, 32'h12345678, rd, er, lat);
    check("oor_err", {31'h0, er}, 32'h1);
    check("oor_latency", lat, 1);
    do_access(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0, rd, er, lat);
    check("oor_word0_kept", rd, 32'hCAFEF00D);
    do_access(1, 1'b0, 4'h0, 32'h0001_0014, 32'h0, rd, er, lat);
    check("oor_read_zero", rd, 32'h0);
    check("oor_read_err", {31'h0, er}, 32'h1);

    // Tie from reset: alternating service, no idle gap.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    set_txn(0, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
    set_txn(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle(seen);
      check($sformatf("tie_seq%0d", k), {30'h0, seen},
            (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
    end
    req_v[1] = 1'b0;
    cycle(seen);
    check("tie_tail_m0", {30'h0, seen}, 32'h1);
    req_v[0] = 1'b0;

    // Idle tie after master 0 was last: round-robin picks 1, fixed priority picks 0.
    set_txn(0, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
    set_txn(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rr_tie_grant", {30'h0, rdy}, 32'h2);
    check("fixed_tie_grant", {30'h0, fx_rdy}, 32'h1);
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    cycle(seen);
    check("rr_tie_then_m0", {30'h0, seen}, 32'h1);
    req_v[0] = 1'b0;

    // Reset during an ACC1 write drops the write at once.
    do_access(0, 1'b1, 4'hF, 32'h0000_0040, 32'h5A5A5A5A, rd, er, lat);
    set_txn(1, 1'b1, 4'hF, 32'h0000_0040, 32'hFFFFFFFF);
    @(posedge clk); #2;
    check("acc1_ready_pre", {31'h0, rdy[1]}, 32'h1);
    check("acc1_we_pre", {31'h0, ram_we}, 32'h1);
    rst = 1'b0;
    #1;
    check("rst_mid_we", {31'h0, ram_we}, 32'h0);
    check("rst_mid_ready", {31'h0, rdy[1]}, 32'h0);
    req_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    set_txn(0, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
    set_txn(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_tie", {30'h0, rdy}, 32'h1);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    cycle(seen);
    check("post_rst_tie_m1", {30'h0, seen}, 32'h2);
    req_v[1] = 1'b0;
    do_access(0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, rd, er, lat);
    check("rst_mid_word_kept", rd, 32'h5A5A5A5A);

    // Random soak from both masters.
    done_cnt = 0; wait_cyc[0] = 0; wait_cyc[1] = 0; stall = 0;
    while (done_cnt < 10000 && !stall) begin
      cycle(seen);
      for (int m = 0; m < 2; m++) begin
        if (req_v[m]) begin
          if (seen[m]) begin
            done_cnt++;
            check("soak_grant_wait", {31'h0, wait_cyc[m] <= 3}, 32'h1);
            wait_cyc[m] = 0;
            if ($urandom_range(9) < 7) rand_txn(m);
            else req_v[m] = 1'b0;
          end else begin
            wait_cyc[m]++;
            if (wait_cyc[m] > 8) begin
              check("soak_stall", wait_cyc[m], 0);
              stall = 1;
            end
          end
        end else if ($urandom_range(1) == 1) begin
          rand_txn(m);
          wait_cyc[m] = 0;
        end
      end
    end
    for (int k = 0; k < 10 && req_v != 2'b00; k++) begin
      cycle(seen);
      for (int m = 0; m < 2; m++) if (req_v[m] && seen[m]) req_v[m] = 1'b0;
    end
    check("drain_done", {30'h0, req_v}, 32'h0);
    @(negedge clk);
    check("final_idle", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
